wb_clint: RTL

Memory-mapped core-local interruptor: the Wishbone slave that sits opposite the LSU's master port. It provides the RISC-V machine timer (`mtime`, `mtimecmp`) and the machine software-interrupt register (`msip`), and drives the timer and software interrupt lines into the core's trap logic. It uses single-beat classic Wishbone with a registered one-cycle acknowledge.

---
 rtl/clint_pkg.sv | 51 +++++
 rtl/wishbone.sv | 17 +
 rtl/clint_prescaler.sv | 32 +++
 rtl/wb_clint.sv | 129 ++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared constants, register decode and byte-merge helper for the core-local interruptor.
package clint_pkg;

    localparam logic [15:0] MSIP_OFF        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [0:0] {
        StIdle,
        StAck
    } bus_state_e;

    typedef enum logic [2:0] {
        RegNone,
        RegMsip,
        RegCmpLo,
        RegCmpHi,
        RegTimeLo,
        RegTimeHi
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [15:0] off);
        case (off)
            MSIP_OFF:        return RegMsip;
            MTIMECMP_LO_OFF: return RegCmpLo;
            MTIMECMP_HI_OFF: return RegCmpHi;
            MTIME_LO_OFF:    return RegTimeLo;
            MTIME_HI_OFF:    return RegTimeHi;
            default:         return RegNone;
        endcase
    endfunction

    // Byte i of the result comes from new_word when sel[i] is set, else from old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/wishbone.sv
// Single-beat classic Wishbone bundle shared by the LSU master and its slaves.
interface wishbone #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0]   ADR;
    logic [XLEN/8-1:0] SEL;
    logic              WE;
    logic              STB;
    logic              CYC;
    logic [XLEN-1:0]   DAT_W;
    logic [XLEN-1:0]   DAT_R;
    logic              ACK;

    modport MASTER (output ADR, SEL, WE, STB, CYC, DAT_W, input DAT_R, ACK);
    modport SLAVE  (input ADR, SEL, WE, STB, DAT_W, output DAT_R, ACK);

endinterface

// File: rtl/clint_prescaler.sv
// Divides the core clock into a one-cycle mtime tick strobe every TICK_DIV cycles.
module clint_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_clint.sv
// Wishbone core-local interruptor: msip, 64-bit mtime/mtimecmp, timer and software IRQs.
// Define CLINT_MTIME_WRITE_EN to make mtime writable; otherwise mtime writes are discarded.
module wb_clint
    import clint_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    wishbone.SLAVE bus,
    output logic   timer_irq,
    output logic   soft_irq
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("wb_clint supports XLEN = 32 only");
    end
    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("wb_clint requires TICK_DIV >= 1");
    end

    bus_state_e  state_q, state_d;
    logic [31:0] dat_r_q, dat_r_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        timer_irq_q;

    logic        tick;
    logic        req;
    logic        wr_en;
    reg_sel_e    reg_sel;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic [63:0] mtime_inc;
    logic        unused_adr;

    clint_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick_o(tick)
    );

    // Requests are only taken in idle, so STB held through the ack cycle is not a new access.
    assign req        = (state_q == StIdle) && bus.STB;
    assign wr_en      = req && bus.WE;
    assign reg_sel    = decode_offset(bus.ADR[15:0]);
    assign wdata      = bus.DAT_W;
    assign sel        = bus.SEL;
    assign unused_adr = ^bus.ADR[31:16];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.STB) state_d = StAck;
            StAck:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            RegMsip:   rdata = {31'b0, msip_q};
            RegCmpLo:  rdata = mtimecmp_q[31:0];
            RegCmpHi:  rdata = mtimecmp_q[63:32];
            RegTimeLo: rdata = mtime_q[31:0];
            RegTimeHi: rdata = mtime_q[63:32];
            default:   rdata = '0;
        endcase
    end

    always_comb begin
        dat_r_d = '0;
        if (req && !bus.WE) begin
            dat_r_d = rdata;
        end
    end

    // Written mtime bytes override the tick; unwritten bytes keep their incremented value.
    always_comb begin
        mtime_inc  = mtime_q + 64'(tick);
        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr_en) begin
            unique case (reg_sel)
                RegMsip: begin
                    if (sel[0]) msip_d = wdata[0];
                end
                RegCmpLo:  mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wdata, sel);
                RegCmpHi:  mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata, sel);
`ifdef CLINT_MTIME_WRITE_EN
                RegTimeLo: mtime_d[31:0]     = merge_bytes(mtime_inc[31:0], wdata, sel);
                RegTimeHi: mtime_d[63:32]    = merge_bytes(mtime_inc[63:32], wdata, sel);
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            dat_r_q     <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= MTIMECMP_RST;
            msip_q      <= 1'b0;
            timer_irq_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dat_r_q     <= dat_r_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            timer_irq_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign bus.ACK   = (state_q == StAck);
    assign bus.DAT_R = dat_r_q;
    assign timer_irq = timer_irq_q;
    assign soft_irq  = msip_q;

endmodule
